hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised pipeline hazard controller for the WISC pipeline. Replaces the separate hazard and forwarding units.
//  Tracks every in-flight register write from EX through WB in a shift-register scoreboard.
//  From that state it produces load-use and branch-register stalls, EX/store forwarding selects, the IF/ID flush,
//  and a whole-pipe freeze driven by a multi-cycle data-memory handshake.
// PARAMETERS
//  RA_W     4   register-index width
//  DEPTH    3   tracked stages after ID: sb[1]=EX, sb[2]=MEM, ..., sb[DEPTH]=WB; legal range 3..8
//  R0_ZERO  1   1: register 0 is hardwired zero and never matches a hazard
//  CNT_W    16  width of the statistics counters
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     reset, synchronous, active low
//  id_valid      in   1     ID holds a real instruction
//  id_rs/id_rt   in   RA_W  ID source registers
//  id_uses_rs    in   1     ID reads rs
//  id_uses_rt    in   1     ID reads rt
//  id_is_store   in   1     ID is SW; rt is store data
//  id_is_load    in   1     ID is LW
//  id_wen        in   1     ID writes a register
//  id_dst        in   RA_W  ID destination register
//  id_br_reg     in   1     ID is BR; rs is needed in ID
//  br_taken      in   1     branch in ID resolved taken
//  mem_req       in   1     MEM stage accesses data memory this cycle
//  mem_ready     in   1     data memory completes this cycle
//  pc_we         out  1     PC write enable
//  if_id_we      out  1     IF/ID latch enable
//  if_id_flush   out  1     clear IF/ID to a bubble
//  id_ex_bubble  out  1     load a bubble into ID/EX
//  freeze        out  1     hold every pipeline latch
//  fwd_a/fwd_b   out  FW    EX operand source; FW=$clog2(DEPTH); 0=regfile, k=stage sb[k+1]
//  fwd_st        out  1     MEM store data comes from WB write data
//  stall_cnt     out  CNT_W cycles with id_ex_bubble=1
//  freeze_cnt    out  CNT_W cycles with freeze=1
//  flush_cnt     out  CNT_W cycles with if_id_flush=1
// BEHAVIOUR
//  - Entry fields: v, wen, dst, load, store, rt.
//  - match(k,r): sb[k].v & sb[k].wen & sb[k].dst==r & ~(R0_ZERO & r==0).
//  - lu_stall = id_valid & sb[1].load & ( (id_uses_rs & match(1,id_rs)) | (id_uses_rt & ~id_is_store & match(1,id_rt)) ).
//    A store whose data comes from a preceding load does not stall; it uses fwd_st.
//  - br_stall = id_valid & id_br_reg & OR(k=1..DEPTH-1) match(k,id_rs).
//    The regfile writes through at WB, so sb[DEPTH] is excluded.
//  - stall = lu_stall | br_stall.
//  - Memory FSM:
//    - RUN: mem_req & ~mem_ready -> WAIT.
//    - WAIT: mem_ready -> RUN.
//    - freeze = (RUN & mem_req & ~mem_ready) | (WAIT & ~mem_ready).
//    - The release cycle (mem_ready=1) has freeze=0.
//  - pc_we = if_id_we = ~stall & ~freeze.
//  - id_ex_bubble = stall & ~freeze.
//  - if_id_flush = br_taken & id_valid & ~stall & ~freeze. A stalled branch is not resolved.
//  - fwd_a: smallest k in 2..DEPTH with match(k, EX rs) & EX uses rs; output k-1, else 0. fwd_b is the same for EX rt.
//    EX rs/rt/uses are held in a side register captured with sb[1].
//  - fwd_st = sb[2].v & sb[2].store & match(DEPTH, sb[2].rt). Only legal when DEPTH==3; tied 0 otherwise.
//  - Clock edge:
//    - freeze=1: all state holds.
//    - otherwise: sb[k] <= sb[k-1] for k>=2.
//    - sb[1] <= ID fields if id_valid & ~stall, else bubble (v=0).
//  - Priority: freeze > stall > flush.
//    - Simultaneous stall and br_taken: stall wins, no flush.
//    - Simultaneous freeze and anything: nothing moves.
//  - Reset (rst_n=0 at an edge):
//    - All sb[k].v=0, EX side register cleared, FSM=RUN, counters=0.
//    - While rst_n=0, combinational outputs are forced to pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=0, freeze=0,
//      fwd_*=0. The CPU latches therefore clear cleanly.
//    - Reset mid-WAIT abandons the access; no freeze after reset release.
//  - Latency: stall, freeze and fwd are combinational from current state and inputs (same cycle).
//    Scoreboard updates take one cycle.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//   - stall_cnt, freeze_cnt and flush_cnt increment on each cycle their event is 1.
//   - They saturate at all-ones (no wrap) and are cleared by reset.
//  HAZARD_STATS_EN undefined:
//   - Counter ports remain but are tied to 0. No counter flops are built.
// TESTING
//  1. LW R1 then ADD R2,R1,R3 -> one cycle id_ex_bubble=1, pc_we=0; next cycle fwd_a=2 (from WB).
//  2. ADD R1 then ADD R4,R1,R1 -> no stall; fwd_a=1 and fwd_b=1 in the ADD's EX cycle.
//  3. LW R5 then SW R5 -> no stall; fwd_st=1 when SW is in MEM.
//  4. ADD R3 then BR via R3, taken ->
//     - two stall cycles (hazard at sb[1], then sb[2]);
//     - then if_id_flush=1 for exactly one cycle; flush_cnt=1 with HAZARD_STATS_EN.
//  5. mem_req=1 with mem_ready low for 3 cycles -> freeze=1 for 3 cycles; scoreboard unchanged; freeze=0 on the
//     ready cycle; freeze_cnt=3.
//  6. Writes targeting R0 (R0_ZERO=1) produce no stall or forward. Reset asserted in WAIT -> after release,
//     freeze=0, all fwd=0, counters=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: scoreboard of in-flight writes, stalls, forwarding, flush and memory freeze.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int unsigned RA_W    = 4,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned R0_ZERO = 1,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned FW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_store,
  input  logic             id_is_load,
  input  logic             id_wen,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_br_reg,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             freeze,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic             fwd_st,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            v;
    logic            wen;
    logic [RA_W-1:0] dst;
    logic            load;
    logic            store;
    logic [RA_W-1:0] rt;
  } sb_entry_t;

  typedef enum logic {ST_RUN, ST_WAIT} mem_st_t;

  sb_entry_t       sb_q [1:DEPTH];
  sb_entry_t       sb_in_d;
  logic [RA_W-1:0] ex_rs_q, ex_rt_q;
  logic            ex_uses_rs_q, ex_uses_rt_q;
  mem_st_t         state_q, state_d;

  logic            lu_stall, br_stall, stall, freeze_raw, fwd_st_raw;
  logic [FW-1:0]   fwd_a_raw, fwd_b_raw;

  function automatic logic match(input sb_entry_t e, input logic [RA_W-1:0] r);
    return e.v & e.wen & (e.dst == r) & ~((R0_ZERO != 0) & (r == '0));
  endfunction

  // Hazard detection and forwarding from the current scoreboard
  always_comb begin
    lu_stall  = 1'b0;
    br_stall  = 1'b0;
    fwd_a_raw = '0;
    fwd_b_raw = '0;
    state_d   = state_q;

    lu_stall = id_valid & sb_q[1].load &
               ((id_uses_rs & match(sb_q[1], id_rs)) |
                (id_uses_rt & ~id_is_store & match(sb_q[1], id_rt)));

    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (id_valid && id_br_reg && match(sb_q[k], id_rs)) br_stall = 1'b1;
    end

    // Walk from the oldest stage down so the youngest producer wins
    for (int unsigned k = DEPTH; k >= 2; k--) begin
      if (ex_uses_rs_q && match(sb_q[k], ex_rs_q)) fwd_a_raw = FW'(k - 1);
      if (ex_uses_rt_q && match(sb_q[k], ex_rt_q)) fwd_b_raw = FW'(k - 1);
    end

    stall      = lu_stall | br_stall;
    freeze_raw = ((state_q == ST_RUN) & mem_req & ~mem_ready) |
                 ((state_q == ST_WAIT) & ~mem_ready);

    case (state_q)
      ST_RUN:  if (mem_req && !mem_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_ready) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    sb_in_d = '0;
    if (id_valid && !stall) begin
      sb_in_d.v     = 1'b1;
      sb_in_d.wen   = id_wen;
      sb_in_d.dst   = id_dst;
      sb_in_d.load  = id_is_load;
      sb_in_d.store = id_is_store;
      sb_in_d.rt    = id_rt;
    end
  end

  // Store-data forwarding only makes sense when WB directly follows MEM
  generate
    if (DEPTH == 3) begin : g_fwd_st
      assign fwd_st_raw = sb_q[2].v & sb_q[2].store & match(sb_q[DEPTH], sb_q[2].rt);
    end else begin : g_no_fwd_st
      assign fwd_st_raw = 1'b0;
    end
  endgenerate

  // Reset forces the pipeline latches to load and clear
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b0;
    freeze       = 1'b0;
    fwd_a        = '0;
    fwd_b        = '0;
    fwd_st       = 1'b0;
    if (rst_n) begin
      pc_we        = ~stall & ~freeze_raw;
      if_id_we     = ~stall & ~freeze_raw;
      if_id_flush  = br_taken & id_valid & ~stall & ~freeze_raw;
      id_ex_bubble = stall & ~freeze_raw;
      freeze       = freeze_raw;
      fwd_a        = fwd_a_raw;
      fwd_b        = fwd_b_raw;
      fwd_st       = fwd_st_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k <= DEPTH; k++) sb_q[k] <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_uses_rs_q <= 1'b0;
      ex_uses_rt_q <= 1'b0;
      state_q      <= ST_RUN;
    end else begin
      state_q <= state_d;
      if (!freeze_raw) begin
        for (int unsigned k = 2; k <= DEPTH; k++) sb_q[k] <= sb_q[k-1];
        sb_q[1]      <= sb_in_d;
        ex_rs_q      <= sb_in_d.v ? id_rs : '0;
        ex_rt_q      <= sb_in_d.v ? id_rt : '0;
        ex_uses_rs_q <= sb_in_d.v & id_uses_rs;
        ex_uses_rt_q <= sb_in_d.v & id_uses_rt;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, freeze_cnt_q, flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (id_ex_bubble && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (freeze && freeze_cnt_q != '1)      freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
      if (if_id_flush && flush_cnt_q != '1)  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign stall_cnt  = '0;
  assign freeze_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected outputs queued per step, popped and checked mid-cycle.
module tb_hazard_scoreboard;
  localparam int unsigned RA_W  = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned FW    = 2;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, id_valid, id_uses_rs, id_uses_rt, id_is_store, id_is_load, id_wen, id_br_reg;
  logic [RA_W-1:0] id_rs, id_rt, id_dst;
  logic br_taken, mem_req, mem_ready;
  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, freeze, fwd_st;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, freeze_cnt, flush_cnt;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_store(id_is_store),
    .id_is_load(id_is_load), .id_wen(id_wen), .id_dst(id_dst), .id_br_reg(id_br_reg),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we),
    .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st),
    .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic pc_we, if_id_we, flush, bubble, freeze;
    logic [FW-1:0] fa, fb;
    logic fst;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_stall = 0, m_freeze = 0, m_flush = 0;

  function automatic exp_t mk(input logic pw, input logic fl, input logic bub, input logic frz,
                              input logic [FW-1:0] fa, input logic [FW-1:0] fb, input logic fst);
    exp_t e;
    e.pc_we = pw; e.if_id_we = pw; e.flush = fl; e.bubble = bub; e.freeze = frz;
    e.fa = fa; e.fb = fb; e.fst = fst;
    return e;
  endfunction

  exp_t E_IDLE, E_STALL, E_RST, E_FRZ;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s.%s got=%0d want=%0d", tag, fld, obs, want);
    end
  endtask

  task automatic id_set(input logic v, input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                        input logic urs, input logic urt, input logic st, input logic ld,
                        input logic wen, input logic [RA_W-1:0] dst, input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_store = st; id_is_load = ld; id_wen = wen; id_dst = dst; id_br_reg = br;
  endtask

  task automatic id_none();
    id_set(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic step(input string tag, input exp_t e);
    exp_t x;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    chk(tag, "pc_we",        32'(pc_we),        32'(x.pc_we));
    chk(tag, "if_id_we",     32'(if_id_we),     32'(x.if_id_we));
    chk(tag, "if_id_flush",  32'(if_id_flush),  32'(x.flush));
    chk(tag, "id_ex_bubble", 32'(id_ex_bubble), 32'(x.bubble));
    chk(tag, "freeze",       32'(freeze),       32'(x.freeze));
    chk(tag, "fwd_a",        32'(fwd_a),        32'(x.fa));
    chk(tag, "fwd_b",        32'(fwd_b),        32'(x.fb));
    chk(tag, "fwd_st",       32'(fwd_st),       32'(x.fst));
    if (rst_n) begin
      chk(tag, "stall_cnt",  32'(stall_cnt),  STATS ? 32'(m_stall)  : 32'd0);
      chk(tag, "freeze_cnt", 32'(freeze_cnt), STATS ? 32'(m_freeze) : 32'd0);
      chk(tag, "flush_cnt",  32'(flush_cnt),  STATS ? 32'(m_flush)  : 32'd0);
    end
    if (!rst_n) begin
      m_stall = 0; m_freeze = 0; m_flush = 0;
    end else begin
      m_stall  += int'(x.bubble);
      m_freeze += int'(x.freeze);
      m_flush  += int'(x.flush);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    E_IDLE  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    E_STALL = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    E_RST   = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    E_FRZ   = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    rst_n = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    id_none();
    step("rst0", E_RST);
    step("rst1", E_RST);
    rst_n = 1'b1;
    step("idle", E_IDLE);

    // Load-use: LW R1; ADD R2,R1,R3
    id_set(1'b1, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
    step("t1_lw", E_IDLE);
    id_set(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    step("t1_stall", E_STALL);
    step("t1_issue", E_IDLE);
    id_none();
    step("t1_fwd", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0));
    step("t1_d0", E_IDLE);
    step("t1_d1", E_IDLE);

    // ALU-ALU forwarding: ADD R1; ADD R4,R1,R1
    id_set(1'b1, 4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
    step("t2_add1", E_IDLE);
    id_set(1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
    step("t2_add2", E_IDLE);
    id_none();
    step("t2_fwd", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0));
    step("t2_d0", E_IDLE);
    step("t2_d1", E_IDLE);

    // Load then store of the loaded register: no stall, store data from WB
    id_set(1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0);
    step("t3_lw", E_IDLE);
    id_set(1'b1, 4'd8, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    step("t3_sw_id", E_IDLE);
    id_none();
    step("t3_sw_ex", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0));
    step("t3_fwd_st", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
    step("t3_d0", E_IDLE);

    // Register branch on a just-written register, taken
    id_set(1'b1, 4'd9, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    step("t4_add", E_IDLE);
    id_set(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    br_taken = 1'b1;
    step("t4_bst1", E_STALL);
    step("t4_bst2", E_STALL);
    step("t4_flush", mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
    br_taken = 1'b0;
    id_none();
    step("t4_after", E_IDLE);
    step("t4_d0", E_IDLE);
    step("t4_d1", E_IDLE);

    // Memory freeze for three cycles holds the forwarding state
    id_set(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
    step("t5_add1", E_IDLE);
    id_set(1'b1, 4'd7, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0);
    step("t5_add2", E_IDLE);
    id_none();
    mem_req = 1'b1; mem_ready = 1'b0;
    step("t5_frz1", mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0));
    step("t5_frz2", mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0));
    step("t5_frz3", mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0));
    mem_ready = 1'b1;
    step("t5_rel", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
    mem_req = 1'b0; mem_ready = 1'b0;
    step("t5_d0", E_IDLE);
    step("t5_d1", E_IDLE);

    // R0 destinations never create hazards
    id_set(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("t6_lw_r0", E_IDLE);
    id_set(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    step("t6_use_r0", E_IDLE);
    id_set(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step("t6_br_r0", E_IDLE);
    id_none();
    step("t6_d0", E_IDLE);

    // Reset in the middle of a memory wait
    id_set(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0);
    step("t7_add1", E_IDLE);
    id_set(1'b1, 4'd12, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd13, 1'b0);
    step("t7_add2", E_IDLE);
    id_none();
    mem_req = 1'b1;
    step("t7_frz1", mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0));
    mem_req = 1'b0;
    step("t7_frz2", mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0));
    rst_n = 1'b0;
    step("t7_rst", E_RST);
    rst_n = 1'b1;
    step("t7_post0", E_IDLE);
    step("t7_post1", E_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
